// File: rtl/hsv_ctrl_pkg.sv
// rtl/hsv_ctrl_pkg.sv - shared types and widths for the HSV stream controller
package hsv_ctrl_pkg;

  localparam int RGB_W = 24;
  localparam int HSV_W = 25;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } tag_t;

  typedef struct packed {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       sop;
    logic       eop;
  } result_t;

endpackage

// File: rtl/hsv_result_fifo.sv
// rtl/hsv_result_fifo.sv - result buffer; space is guaranteed by upstream credits
module hsv_result_fifo
  import hsv_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  result_t          wdata,
  input  logic             pop,
  output result_t          rdata,
  output logic [CNT_W-1:0] count
);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/hsv_stream_ctrl.sv
// rtl/hsv_stream_ctrl.sv - RGB->HSV converter sequencer; HSV_CTRL_STATS_EN adds frame/drop counters
module hsv_stream_ctrl
  import hsv_ctrl_pkg::*;
#(
  parameter int CVT_LAT = 3,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RGB_W-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             cvt_rst_n,
  output logic [7:0]       cvt_r,
  output logic [7:0]       cvt_g,
  output logic [7:0]       cvt_b,
  input  logic [8:0]       cvt_h,
  input  logic [7:0]       cvt_s,
  input  logic [7:0]       cvt_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HSV_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             err_sop
`ifdef HSV_CTRL_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  state_t           state;
  tag_t             tag [CVT_LAT];
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   used;
  logic             accept;
  logic             fwd;
  logic             pop;
  result_t          wr_res;
  result_t          rd_res;

  assign cvt_rst_n = ~rst;
  assign accept    = in_valid && in_ready;
  assign fwd       = accept && ((state == ACTIVE) || in_sop);
  assign {cvt_r, cvt_g, cvt_b} = fwd ? in_data : '0;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CVT_LAT; i++) inflight = inflight + CNT_W'(tag[i].valid);
  end

  // Credits cover both buffered and in-flight pixels, so a non-stallable push always has room.
  assign used     = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready = used < DEPTH_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CVT_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= {fwd, fwd && in_sop, fwd && in_eop};
      for (int i = 1; i < CVT_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign wr_res = {cvt_h, cvt_s, cvt_v, tag[CVT_LAT-1].sop, tag[CVT_LAT-1].eop};
  assign pop    = out_valid && out_ready;

  hsv_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag[CVT_LAT-1].valid),
    .wdata (wr_res),
    .pop   (pop),
    .rdata (rd_res),
    .count (fifo_count)
  );

  assign out_valid = fifo_count != '0;
  assign out_data  = out_valid ? {rd_res.h, rd_res.s, rd_res.v} : '0;
  assign out_sop   = out_valid && rd_res.sop;
  assign out_eop   = out_valid && rd_res.eop;

  // An SOP seen while ACTIVE restarts the frame and latches the error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      err_sop <= 1'b0;
    end else if (accept) begin
      if ((state == ACTIVE) && in_sop) err_sop <= 1'b1;
      if (fwd) state <= in_eop ? IDLE : ACTIVE;
    end
  end

`ifdef HSV_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (fwd && in_eop && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if (accept && !fwd && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// tb/tb_hsv_stream_ctrl.sv - self-checking bench for hsv_stream_ctrl
module tb_hsv_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        cvt_rst_n;
  logic [7:0]  cvt_r, cvt_g, cvt_b;
  logic [8:0]  cvt_h;
  logic [7:0]  cvt_s, cvt_v;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        err_sop;
`ifdef HSV_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  hsv_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .cvt_rst_n (cvt_rst_n),
    .cvt_r     (cvt_r),
    .cvt_g     (cvt_g),
    .cvt_b     (cvt_b),
    .cvt_h     (cvt_h),
    .cvt_s     (cvt_s),
    .cvt_v     (cvt_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .err_sop   (err_sop)
`ifdef HSV_CTRL_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc;
  int stalls;

  always @(posedge clk) cyc <= cyc + 1;

  // Integer RGB->HSV: hue in degrees, S and V scaled to 0..255.
  function automatic logic [24:0] hsv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int mx, mn, d, h, s;
    mx = (r >= g) ? ((r >= b) ? r : b) : ((g >= b) ? g : b);
    mn = (r <= g) ? ((r <= b) ? r : b) : ((g <= b) ? g : b);
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (255 * d) / mx;
    if (d == 0)       h = 0;
    else if (mx == r) h = (60 * (int'(g) - int'(b)) / d + 360) % 360;
    else if (mx == g) h = 120 + 60 * (int'(b) - int'(r)) / d;
    else              h = 240 + 60 * (int'(r) - int'(g)) / d;
    return {h[8:0], s[7:0], mx[7:0]};
  endfunction

  function automatic logic [23:0] pix(input int k);
    return {8'(120 + k), 8'((k * 3) % 50), 8'((k * 7) % 40)};
  endfunction

  // Converter model: three register stages, cleared by its own reset.
  logic [24:0] cp0, cp1, cp2;
  always @(posedge clk or negedge cvt_rst_n) begin
    if (!cvt_rst_n) begin
      cp0 <= '0; cp1 <= '0; cp2 <= '0;
    end else begin
      cp0 <= hsv(cvt_r, cvt_g, cvt_b);
      cp1 <= cp0;
      cp2 <= cp1;
    end
  end
  assign {cvt_h, cvt_s, cvt_v} = cp2;

  typedef struct {
    logic [24:0] d;
    logic        s;
    logic        e;
    int          c;
  } res_t;
  res_t got[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
  endtask

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at 0");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wait_results(input int n, input string nm);
    int t;
    t = 0;
    while (got.size() < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(nm, got.size(), n);
  endtask

  task automatic check_stream(input int n, input string nm);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++) if (i >= got.size() || got[i].d !== hsv(pix(i)[23:16], pix(i)[15:8], pix(i)[7:0])) mism++;
    chk(nm, mism, 0);
  endtask

  typedef struct {
    logic [23:0] rgb;
    logic [24:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int acc0, acc, gaps;
    vecs[0] = '{24'hFF0000, {9'd0,   8'd255, 8'd255}};
    vecs[1] = '{24'h00FF00, {9'd120, 8'd255, 8'd255}};
    vecs[2] = '{24'h0000FF, {9'd240, 8'd255, 8'd255}};
    vecs[3] = '{24'hFFFF00, {9'd60,  8'd255, 8'd255}};
    vecs[4] = '{24'h00FFFF, {9'd180, 8'd255, 8'd255}};
    vecs[5] = '{24'hFFFFFF, {9'd0,   8'd0,   8'd255}};
    vecs[6] = '{24'h000000, {9'd0,   8'd0,   8'd0}};
    vecs[7] = '{24'hFF0080, {9'd330, 8'd255, 8'd255}};
    vecs[8] = '{24'hC86432, {9'd20,  8'd191, 8'd200}};

    // Reset values
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_err_sop", err_sop, 0);
    chk("rst_cvt_rgb", {cvt_r, cvt_g, cvt_b}, 0);
    chk("rst_cvt_rst_n", cvt_rst_n, 0);
    do_reset();

    // 4-pixel red frame, latency and markers
    send(24'hFF0000, 1'b1, 1'b0);
    acc0 = acc_cyc;
    send(24'hFF0000, 1'b0, 1'b0);
    send(24'hFF0000, 1'b0, 1'b0);
    send(24'hFF0000, 1'b0, 1'b1);
    wait_results(4, "frame4_count");
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("frame4_cycle%0d", i), got[i].c - acc0, 3 + i);
      chk($sformatf("frame4_data%0d", i), got[i].d, {9'd0, 8'd255, 8'd255});
      chk($sformatf("frame4_sop%0d", i), got[i].s, (i == 0));
      chk($sformatf("frame4_eop%0d", i), got[i].e, (i == 3));
    end

    // Non-SOP beats in IDLE are dropped
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(pix(i), 1'b0, 1'b0);
      chk($sformatf("drop_ready%0d", i), in_ready, 1);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("drop_no_output", got.size(), 0);
`ifdef HSV_CTRL_STATS_EN
    chk("drop_cnt", drop_cnt, 3);
`endif

    // Table of single-pixel frames
    do_reset();
    for (int v = 0; v < 9; v++) begin
      got.delete();
      send(vecs[v].rgb, 1'b1, 1'b1);
      wait_results(1, $sformatf("vec%0d_count", v));
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_data", v), got[0].d, vecs[v].exp);
        chk($sformatf("vec%0d_marks", v), {got[0].s, got[0].e}, 2'b11);
      end
    end
`ifdef HSV_CTRL_STATS_EN
    chk("frame_cnt", frame_cnt, 9);
`endif

    // Backpressure: 20 beats offered with out_ready low
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = pix(acc); in_sop = (acc == 0); in_eop = 1'b0;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sop = 1'b0;
    chk("bp_accepted", acc, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_no_output", got.size(), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_during_pop", in_ready, 0);
    @(negedge clk);
    chk("bp_ready_after_pop", in_ready, 1);
    wait_results(8, "bp_drain_count");
    check_stream(8, "bp_drain_order");
    for (int k = 8; k < 20; k++) send(pix(k), 1'b0, (k == 19));
    wait_results(20, "bp_total_count");
    check_stream(20, "bp_total_order");

    // Sustained streaming
    do_reset();
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      send(pix(k), (k == 0), (k == 63));
      if (k == 0) acc0 = acc_cyc;
    end
    chk("sus_stalls", stalls, 0);
    wait_results(64, "sus_count");
    check_stream(64, "sus_order");
    gaps = 0;
    for (int i = 1; i < got.size(); i++) if (got[i].c != got[i-1].c + 1) gaps++;
    chk("sus_gaps", gaps, 0);
    if (got.size() > 0) chk("sus_latency", got[0].c - acc0, 3);

    // SOP in the middle of a frame
    do_reset();
    send(pix(0), 1'b1, 1'b0);
    send(pix(1), 1'b0, 1'b0);
    chk("midsop_err_before", err_sop, 0);
    send(pix(2), 1'b1, 1'b0);
    chk("midsop_err_set", err_sop, 1);
    send(pix(3), 1'b0, 1'b1);
    wait_results(4, "midsop_count");
    if (got.size() == 4) chk("midsop_marks", {got[0].s, got[1].s, got[2].s, got[3].s, got[3].e}, 5'b10101);
    repeat (3) @(posedge clk);
    #1;
    chk("midsop_sticky", err_sop, 1);

    // Reset with 3 in flight and 2 buffered
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(pix(k), (k == 0), 1'b0);
    chk("rstmid_buffered", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    repeat (12) @(posedge clk);
    #1;
    chk("rstmid_no_stale", got.size(), 0);
    send(pix(5), 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid_idle_drop", got.size(), 0);
    send(24'hFF0000, 1'b1, 1'b1);
    wait_results(1, "rstmid_new_frame");
    chk("rstmid_err_clear", err_sop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_stream_ctrl.md
# hsv_stream_ctrl

Stream controller that sequences the pixel-level RGB→HSV converter for one camera stream. It accepts RGB beats over a valid/ready handshake and drives the converter's free-running, non-stallable pipeline. It tracks in-flight pixels with a tag shift register and buffers results in an output FIFO, so downstream backpressure never loses a pixel. Frame boundaries are enforced with a small state machine. It sits between the camera pixel source and the colour-thresholding stage.

## Interface
Parameters:
- CVT_LAT, 3, converter latency in clock edges from input to registered H/S/V.
- DEPTH, 8, output FIFO entries; must be a power of two and ≥ CVT_LAT+2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  source beat valid.
- in_ready  out  1  controller accepts beat.
- in_data  in  24  {R[23:16], G[15:8], B[7:0]}.
- in_sop / in_eop  in  1  first / last pixel of frame.
- cvt_rst_n  out  1  converter reset, equal to ~rst (combinational).
- cvt_r / cvt_g / cvt_b  out  8  converter inputs.
- cvt_h  in  9, cvt_s  in  8, cvt_v  in  8  converter outputs.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- out_data  out  25  {H[24:16], S[15:8], V[7:0]}.
- out_sop / out_eop  out  1  frame markers aligned with out_data.
- err_sop  out  1  sticky: SOP seen mid-frame.

## Operation
- Acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready = (fifo_count + inflight) < DEPTH, computed from registered state only. There is no combinational path from out_ready.
- cvt_r/g/b = in_data fields when a beat is accepted in state ACTIVE, or when an SOP beat is accepted in IDLE; otherwise 0.
- Tag pipe: CVT_LAT stages of {valid, sop, eop}. Stage 0 loads on every edge with the acceptance-forwarded flag. inflight = popcount of the valid bits.
- When tag[CVT_LAT-1].valid is set, {cvt_h, cvt_s, cvt_v, sop, eop} is written to the FIFO that cycle. A write can never find the FIFO full, because credit guarantees space.
- FIFO pop occurs on out_valid && out_ready. Simultaneous push and pop are allowed and leave count unchanged. Read and write pointers wrap modulo DEPTH.
- out_valid = fifo_count ≠ 0. out_data and markers show the head entry and stay stable while out_ready is low.
- State machine:
  - IDLE: in_ready follows the credit rule. Accepted non-SOP beats are discarded (not forwarded). An accepted SOP beat is forwarded; go to ACTIVE, or stay in IDLE if the beat is also EOP (1-pixel frame).
  - ACTIVE: all accepted beats are forwarded. An accepted EOP goes to IDLE. An accepted SOP sets err_sop, is forwarded as a new frame start, and the state stays ACTIVE.
- err_sop clears only on reset.
- Reset mid-frame: the tag pipe, FIFO pointers and count, state and err_sop are all cleared. In-flight converter data is dropped.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_sop 0, out_eop 0, err_sop 0, cvt_r/g/b 0, state IDLE.
- Latency: a beat accepted in cycle c gives the earliest out_valid in cycle c+CVT_LAT (3 with defaults).
- Throughput: 1 pixel/cycle sustained when out_ready is held high, for DEPTH ≥ CVT_LAT+2.
- Backpressure: with out_ready low, at most DEPTH beats are accepted before in_ready drops. in_ready rises one cycle after the pop that frees a credit.

## Configuration
- HSV_CTRL_STATS_EN defined: adds outputs frame_cnt[15:0] and drop_cnt[15:0].
  - frame_cnt increments on each accepted EOP beat that is forwarded.
  - drop_cnt increments on each beat discarded in IDLE.
  - Both saturate at 16'hFFFF and reset to 0.
- HSV_CTRL_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package hsv_ctrl_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - the tag struct {valid, sop, eop};
  - the result struct {h[8:0], s[7:0], v[7:0], sop, eop};
  - field-width constants (RGB_W=24, HSV_W=25).
- One sub-module, hsv_result_fifo: parameterised DEPTH, synchronous push/pop, count output, no overflow protection (guaranteed by credits).
- The converter is instantiated by the integrating top, not inside this block.

## Test plan
- Reset, then a 4-pixel frame (SOP on beat 0, EOP on beat 3) with out_ready=1:
  - outputs appear at cycles 3–6;
  - out_sop is set only on the first result and out_eop only on the last;
  - the bench converter model gives pure red (255,0,0) → H=0, S=255, V=255.
- Beats without SOP in IDLE: 3 beats → no outputs, in_ready stays 1, drop_cnt=3 (STATS_EN build).
- Backpressure: out_ready=0, stream 20 beats:
  - exactly 8 beats are accepted and in_ready drops;
  - releasing out_ready drains all 8 in order, then acceptance resumes;
  - no loss and no duplication.
- Sustained streaming: 64 beats with out_ready=1 → in_ready never drops and 64 results are produced back-to-back.
- SOP mid-frame: SOP again at beat 2 of an active frame → err_sop=1, and the beat is forwarded with out_sop=1.
- Reset asserted while 3 pixels are in flight and 2 are buffered:
  - out_valid=0 immediately;
  - no stale results after deassertion;
  - state is IDLE.
